// File: rtl/dense_layer_folded.sv
// Folded fully connected layer: NUM_LANES MAC lanes are time-shared across the neurons,
// followed by floor requantisation, saturation and an optional ReLU, with a loadable weight/bias store.
package dense_layer_folded_pkg;
   parameter int INTEGER_WIDTH  = 8;
   parameter int FRACTION_WIDTH = 8;
   typedef enum logic [1:0] {NONE, RELU} activation_type;
endpackage

module dense_layer_folded
   import dense_layer_folded_pkg::*;
#(
   parameter int             NUM_INPUTS  = 16,
   parameter int             NUM_NEURONS = 16,
   parameter int             NUM_LANES   = 4,
   parameter activation_type ACTIVATION  = RELU,
   localparam int W        = INTEGER_WIDTH + FRACTION_WIDTH,
   localparam int NEURON_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
   localparam int IDX_W    = $clog2(NUM_INPUTS + 1)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                weight_write,
   input  logic [NEURON_W-1:0] weight_neuron,
   input  logic [IDX_W-1:0]    weight_index,
   input  logic signed [W-1:0] weight_value,
   input  logic                inputs_ready,
   input  logic signed [W-1:0] inputs [NUM_INPUTS],
   output logic                busy,
   output logic signed [W-1:0] outputs [NUM_NEURONS],
   output logic                outputs_ready
);

   localparam int GROUPS  = NUM_NEURONS / NUM_LANES;
   localparam int GROUP_W = (GROUPS > 1) ? $clog2(GROUPS) : 1;
   localparam int ACC_W   = 2 * W + $clog2(NUM_INPUTS + 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (W - 1)));

   if (NUM_INPUTS < 1 || NUM_NEURONS < 1 || NUM_LANES < 1) begin : g_bad_size
      $error("dense_layer_folded: NUM_INPUTS, NUM_NEURONS and NUM_LANES must be >= 1");
   end
   if (NUM_NEURONS % NUM_LANES != 0) begin : g_bad_lanes
      $error("dense_layer_folded: NUM_LANES must divide NUM_NEURONS");
   end
   if (ACTIVATION != NONE && ACTIVATION != RELU) begin : g_bad_act
      $error("dense_layer_folded: unsupported ACTIVATION");
   end

   typedef enum logic [1:0] {IDLE, MAC, FINISH} state_t;

   state_t                state;
   logic [GROUP_W-1:0]    group;
   logic [IDX_W-1:0]      idx;
   logic signed [W-1:0]   weight_mem [NUM_NEURONS][NUM_INPUTS];
   logic signed [W-1:0]   bias_mem   [NUM_NEURONS];
   logic signed [W-1:0]   in_reg     [NUM_INPUTS];
   logic signed [ACC_W-1:0] acc      [NUM_LANES];
   logic signed [W-1:0]   shadow     [NUM_NEURONS];

   logic signed [W-1:0]     x_sel;
   logic signed [W-1:0]     w_sel       [NUM_LANES];
   logic signed [2*W-1:0]   prod        [NUM_LANES];
   logic signed [W-1:0]     bias_first  [NUM_LANES];
   logic signed [W-1:0]     bias_next   [NUM_LANES];
   logic signed [W-1:0]     lane_result [NUM_LANES];
   logic                    last_group;

   function automatic logic signed [ACC_W-1:0] bias_to_acc(input logic signed [W-1:0] b);
      logic signed [ACC_W-1:0] e;
      e = ACC_W'(b);
      return e <<< FRACTION_WIDTH;
   endfunction

   // Floor shift back to W bits, clamp, then the optional ReLU.
   function automatic logic signed [W-1:0] requant(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W-1:0] s;
      logic signed [W-1:0]     r;
      s = a >>> FRACTION_WIDTH;
      if (s > SAT_MAX)      r = SAT_MAX[W-1:0];
      else if (s < SAT_MIN) r = SAT_MIN[W-1:0];
      else                  r = s[W-1:0];
      if (ACTIVATION == RELU && r[W-1]) r = '0;
      return r;
   endfunction

   always_comb begin
      x_sel = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         if (idx == IDX_W'(i)) x_sel = in_reg[i];
      end
      last_group = (group == GROUP_W'(GROUPS - 1));
      for (int l = 0; l < NUM_LANES; l++) begin
         w_sel[l]       = '0;
         bias_next[l]   = '0;
         bias_first[l]  = bias_mem[l];
         lane_result[l] = requant(acc[l]);
         // A bias written on the accepting edge must already seed the first group.
         if (weight_write && weight_index == IDX_W'(NUM_INPUTS) && weight_neuron == NEURON_W'(l))
            bias_first[l] = weight_value;
         for (int g = 0; g < GROUPS; g++) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
               if (group == GROUP_W'(g) && idx == IDX_W'(i))
                  w_sel[l] = weight_mem[g*NUM_LANES+l][i];
            end
         end
         for (int g = 1; g < GROUPS; g++) begin
            if (group == GROUP_W'(g - 1)) bias_next[l] = bias_mem[g*NUM_LANES+l];
         end
         prod[l] = (2*W)'(x_sel) * (2*W)'(w_sel[l]);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         busy          <= 1'b0;
         outputs_ready <= 1'b0;
         group         <= '0;
         idx           <= '0;
         for (int n = 0; n < NUM_NEURONS; n++) begin
            outputs[n]  <= '0;
            bias_mem[n] <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) weight_mem[n][i] <= '0;
         end
      end else begin
         outputs_ready <= 1'b0;
         if (weight_write && !busy) begin
            for (int n = 0; n < NUM_NEURONS; n++) begin
               if (weight_neuron == NEURON_W'(n)) begin
                  for (int i = 0; i < NUM_INPUTS; i++) begin
                     if (weight_index == IDX_W'(i)) weight_mem[n][i] <= weight_value;
                  end
                  if (weight_index == IDX_W'(NUM_INPUTS)) bias_mem[n] <= weight_value;
               end
            end
         end
         case (state)
            IDLE: begin
               if (inputs_ready) begin
                  for (int i = 0; i < NUM_INPUTS; i++) in_reg[i] <= inputs[i];
                  for (int l = 0; l < NUM_LANES; l++) acc[l] <= bias_to_acc(bias_first[l]);
                  group <= '0;
                  idx   <= '0;
                  busy  <= 1'b1;
                  state <= MAC;
               end
            end
            MAC: begin
               for (int l = 0; l < NUM_LANES; l++) acc[l] <= acc[l] + ACC_W'(prod[l]);
               idx <= idx + 1'b1;
               if (idx == IDX_W'(NUM_INPUTS - 1)) state <= FINISH;
            end
            FINISH: begin
               for (int g = 0; g < GROUPS; g++) begin
                  for (int l = 0; l < NUM_LANES; l++) begin
                     if (group == GROUP_W'(g)) shadow[g*NUM_LANES+l] <= lane_result[l];
                  end
               end
               if (!last_group) begin
                  for (int l = 0; l < NUM_LANES; l++) acc[l] <= bias_to_acc(bias_next[l]);
                  group <= group + 1'b1;
                  idx   <= '0;
                  state <= MAC;
               end else begin
                  // Final group bypasses the shadow so all outputs change on one edge.
                  for (int g = 0; g < GROUPS; g++) begin
                     for (int l = 0; l < NUM_LANES; l++) begin
                        outputs[g*NUM_LANES+l] <= (group == GROUP_W'(g)) ? lane_result[l]
                                                                          : shadow[g*NUM_LANES+l];
                     end
                  end
                  outputs_ready <= 1'b1;
                  busy          <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dense_layer_folded.sv
// Directed bench: two 4x4/2-lane instances (RELU and NONE) sharing stimulus, plus the
// default 16x16/4-lane instance checked against a reference model on random sets.
module tb_dense_layer_folded;
   import dense_layer_folded_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   logic               s_ww, s_ir;
   logic [1:0]         s_wn;
   logic [2:0]         s_wi;
   logic signed [15:0] s_wv;
   logic signed [15:0] s_in [4];
   logic               r_busy, r_ordy, n_busy, n_ordy;
   logic signed [15:0] r_out [4];
   logic signed [15:0] n_out [4];

   logic               d_ww, d_ir, d_busy, d_ordy;
   logic [3:0]         d_wn;
   logic [4:0]         d_wi;
   logic signed [15:0] d_wv;
   logic signed [15:0] d_in  [16];
   logic signed [15:0] d_out [16];

   logic signed [15:0] dw [16][16];
   logic signed [15:0] db [16];
   logic signed [15:0] dx [16];

   int checks = 0;
   int errors = 0;

   dense_layer_folded #(.NUM_INPUTS(4), .NUM_NEURONS(4), .NUM_LANES(2), .ACTIVATION(RELU)) u_relu (
      .clock(clk), .reset(reset), .weight_write(s_ww), .weight_neuron(s_wn), .weight_index(s_wi),
      .weight_value(s_wv), .inputs_ready(s_ir), .inputs(s_in), .busy(r_busy), .outputs(r_out),
      .outputs_ready(r_ordy));

   dense_layer_folded #(.NUM_INPUTS(4), .NUM_NEURONS(4), .NUM_LANES(2), .ACTIVATION(NONE)) u_none (
      .clock(clk), .reset(reset), .weight_write(s_ww), .weight_neuron(s_wn), .weight_index(s_wi),
      .weight_value(s_wv), .inputs_ready(s_ir), .inputs(s_in), .busy(n_busy), .outputs(n_out),
      .outputs_ready(n_ordy));

   dense_layer_folded u_def (
      .clock(clk), .reset(reset), .weight_write(d_ww), .weight_neuron(d_wn), .weight_index(d_wi),
      .weight_value(d_wv), .inputs_ready(d_ir), .inputs(d_in), .busy(d_busy), .outputs(d_out),
      .outputs_ready(d_ordy));

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic s_write(input int n, input int i, input logic [15:0] v);
      s_ww = 1'b1; s_wn = 2'(n); s_wi = 3'(i); s_wv = v;
      tick();
      s_ww = 1'b0;
   endtask

   task automatic s_fill(input logic [15:0] w, input logic [15:0] b);
      for (int n = 0; n < 4; n++) begin
         for (int i = 0; i < 4; i++) s_write(n, i, w);
         s_write(n, 4, b);
      end
   endtask

   task automatic s_set(input logic [15:0] a0, input logic [15:0] a1,
                        input logic [15:0] a2, input logic [15:0] a3);
      s_in[0] = a0; s_in[1] = a1; s_in[2] = a2; s_in[3] = a3;
   endtask

   task automatic s_wait(output int lat, output int bcnt);
      lat = 0; bcnt = 0;
      while (!r_ordy && lat < 100) begin
         if (r_busy) bcnt++;
         tick();
         lat++;
      end
   endtask

   // Packed expectations: element k lives in bits [16k +: 16].
   task automatic s_expect(input string tag, input logic [63:0] er, input logic [63:0] en);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("%s_relu%0d", tag, k), r_out[k], er[16*k +: 16]);
         check($sformatf("%s_none%0d", tag, k), n_out[k], en[16*k +: 16]);
      end
   endtask

   task automatic s_run(input string tag, input int exp_lat, input logic [63:0] er, input logic [63:0] en);
      int lat, bcnt;
      s_ir = 1'b1;
      tick();
      s_ir = 1'b0;
      s_wait(lat, bcnt);
      check({tag, "_lat"}, 16'(lat), 16'(exp_lat));
      check({tag, "_none_rdy"}, 16'(n_ordy), 16'd1);
      s_expect(tag, er, en);
   endtask

   task automatic d_write(input int n, input int i, input logic [15:0] v);
      d_ww = 1'b1; d_wn = 4'(n); d_wi = 5'(i); d_wv = v;
      tick();
      d_ww = 1'b0;
   endtask

   function automatic logic [15:0] ref_neuron(input int n);
      longint a;
      a = longint'(db[n]) * 256;
      for (int i = 0; i < 16; i++) a += longint'(dx[i]) * longint'(dw[n][i]);
      a = a >>> 8;
      if (a > 32767) a = 32767;
      else if (a < -32768) a = -32768;
      if (a < 0) a = 0;
      return 16'(a);
   endfunction

   initial begin
      int lat, bcnt, quiet, nbad, t;
      logic [15:0] e;
      reset = 1'b1;
      s_ww = 0; s_ir = 0; s_wn = 0; s_wi = 0; s_wv = 0; s_set(0, 0, 0, 0);
      d_ww = 0; d_ir = 0; d_wn = 0; d_wi = 0; d_wv = 0;
      for (int i = 0; i < 16; i++) d_in[i] = '0;
      tick(); tick();
      reset = 1'b0;

      check("rst_relu_busy", 16'(r_busy), 16'd0);
      check("rst_relu_rdy", 16'(r_ordy), 16'd0);
      check("rst_none_busy", 16'(n_busy), 16'd0);
      check("rst_def_busy", 16'(d_busy), 16'd0);
      check("rst_def_rdy", 16'(d_ordy), 16'd0);
      s_expect("rst", 64'h0, 64'h0);
      for (int k = 0; k < 16; k++) check($sformatf("rst_def_out%0d", k), d_out[k], 16'h0000);

      // Identity weights
      for (int n = 0; n < 4; n++)
         for (int i = 0; i < 4; i++) s_write(n, i, (n == i) ? 16'h0100 : 16'h0000);
      s_set(16'h0080, 16'h0140, 16'hFE00, 16'h0300);
      s_ir = 1'b1;
      tick();
      s_ir = 1'b0;
      s_wait(lat, bcnt);
      check("id_lat", 16'(lat), 16'd10);
      check("id_busy_cycles", 16'(bcnt), 16'd10);
      check("id_busy_after", 16'(r_busy), 16'd0);
      s_expect("id", {16'h0300, 16'h0000, 16'h0140, 16'h0080}, {16'h0300, 16'hFE00, 16'h0140, 16'h0080});
      tick();
      check("id_rdy_pulse", 16'(r_ordy), 16'd0);

      // Bias only
      s_fill(16'h0000, 16'hFE80);
      s_run("bias", 10, 64'h0, {4{16'hFE80}});

      // Saturation
      s_fill(16'h6400, 16'h0000);
      s_set(16'h0100, 16'h0100, 16'h0100, 16'h0100);
      s_run("sat_pos", 10, {4{16'h7FFF}}, {4{16'h7FFF}});
      s_set(16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00);
      s_run("sat_neg", 10, 64'h0, {4{16'h8000}});

      // Floor rounding
      s_fill(16'h0080, 16'h0000);
      s_set(16'h0001, 16'h0000, 16'h0000, 16'h0000);
      s_run("rnd_pos", 10, 64'h0, 64'h0);
      s_set(16'hFFFF, 16'h0000, 16'h0000, 16'h0000);
      s_run("rnd_neg", 10, 64'h0, {4{16'hFFFF}});

      // Start and weight write pulsed mid-run are ignored
      s_set(16'h0100, 16'h0100, 16'h0100, 16'h0100);
      s_ir = 1'b1;
      tick();
      s_ir = 1'b0;
      tick(); tick(); tick();
      s_ir = 1'b1;
      s_set(16'h0300, 16'h0300, 16'h0300, 16'h0300);
      s_write(0, 0, 16'h7000);
      s_ir = 1'b0;
      s_wait(lat, bcnt);
      check("mid_lat", 16'(lat), 16'd6);
      s_expect("mid", {4{16'h0200}}, {4{16'h0200}});
      quiet = 0;
      for (int c = 0; c < 15; c++) begin
         tick();
         if (r_ordy || r_busy) quiet++;
      end
      check("mid_no_rerun", 16'(quiet), 16'd0);

      // inputs_ready held through the completion cycle
      s_set(16'h0100, 16'h0100, 16'h0100, 16'h0100);
      s_ir = 1'b1;
      tick();
      s_wait(lat, bcnt);
      check("b2b_lat1", 16'(lat), 16'd10);
      s_expect("b2b1", {4{16'h0200}}, {4{16'h0200}});
      s_set(16'h0200, 16'h0200, 16'h0200, 16'h0200);
      tick();
      s_ir = 1'b0;
      check("b2b_accept", 16'(r_busy), 16'd1);
      s_wait(lat, bcnt);
      check("b2b_lat2", 16'(lat), 16'd10);
      s_expect("b2b2", {4{16'h0400}}, {4{16'h0400}});

      // Reset mid-run
      s_ir = 1'b1;
      tick();
      s_ir = 1'b0;
      tick(); tick(); tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rstmid_busy", 16'(r_busy), 16'd0);
      check("rstmid_none_busy", 16'(n_busy), 16'd0);
      quiet = 0;
      for (int c = 0; c < 15; c++) begin
         tick();
         if (r_ordy || n_ordy) quiet++;
      end
      check("rstmid_no_rdy", 16'(quiet), 16'd0);
      s_expect("rstmid", 64'h0, 64'h0);

      // Bias written on the accepting edge applies to that run
      s_set(16'h0100, 16'h0100, 16'h0100, 16'h0100);
      s_ir = 1'b1;
      s_write(1, 4, 16'h0100);
      s_ir = 1'b0;
      s_wait(lat, bcnt);
      check("accw_lat", 16'(lat), 16'd10);
      s_expect("accw", {16'h0, 16'h0, 16'h0100, 16'h0}, {16'h0, 16'h0, 16'h0100, 16'h0});

      // Default geometry against the reference model
      for (int set = 0; set < 100; set++) begin
         for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < 16; i++) begin
               if (set < 50) begin
                  t = int'($urandom_range(0, 1023)) - 512;
                  dw[n][i] = 16'(t);
               end else begin
                  dw[n][i] = 16'($urandom);
               end
               d_write(n, i, dw[n][i]);
            end
            db[n] = 16'($urandom);
            d_write(n, 16, db[n]);
         end
         for (int i = 0; i < 16; i++) begin
            if (set < 50) begin
               t = int'($urandom_range(0, 2047)) - 1024;
               dx[i] = 16'(t);
            end else begin
               dx[i] = 16'($urandom);
            end
            d_in[i] = dx[i];
         end
         d_ir = 1'b1;
         tick();
         d_ir = 1'b0;
         lat = 0;
         while (!d_ordy && lat < 200) begin
            tick();
            lat++;
         end
         check($sformatf("def%0d_lat", set), 16'(lat), 16'd68);
         nbad = 0;
         for (int n = 0; n < 16; n++) begin
            e = ref_neuron(n);
            if (d_out[n] !== e) nbad++;
         end
         check($sformatf("def%0d_bad_outputs", set), 16'(nbad), 16'd0);
         check($sformatf("def%0d_out%0d", set, set % 16), d_out[set % 16], ref_neuron(set % 16));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
